// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux, round-robin or fixed select, one register stage
module stream_mux_rr #(
   parameter int N_CH  = 16,
   parameter int WIDTH = 1,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] In_Data,
   input  logic [N_CH-1:0]       In_Valid,
   output logic [N_CH-1:0]       In_Ready,
   input  logic                  Mode,
   input  logic [SEL_W-1:0]      Sel,
   output logic [WIDTH-1:0]      Out_Data,
   output logic [SEL_W-1:0]      Out_Sel,
   output logic                  Out_Valid,
   input  logic                  Out_Ready
);
   logic [SEL_W-1:0] last, rr_idx, idx;
   logic             rr_hit, fx_hit, hit, ld, go;
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      for (int i = N_CH; i >= 1; i--) begin
         if (In_Valid[(int'(last) + i) % N_CH]) begin
            rr_hit = 1'b1;
            rr_idx = SEL_W'((int'(last) + i) % N_CH);
         end
      end
   end
   // out-of-range Sel must never grant, so guard before indexing
   assign fx_hit   = (int'(Sel) < N_CH) ? In_Valid[Sel] : 1'b0;
   assign hit      = Mode ? fx_hit : rr_hit;
   assign idx      = Mode ? Sel : rr_idx;
   assign ld       = ~Out_Valid | Out_Ready;
   assign go       = ld & hit;
   assign In_Ready = (rst_n & go) ? N_CH'(1) << idx : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Out_Valid <= 1'b0;
         Out_Data  <= '0;
         Out_Sel   <= '0;
         last      <= SEL_W'(N_CH - 1);
      end else if (go) begin
         Out_Valid <= 1'b1;
         Out_Data  <= In_Data[idx*WIDTH +: WIDTH];
         Out_Sel   <= idx;
         if (!Mode) last <= idx;
      end else if (Out_Ready) begin
         Out_Valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks of stream_mux_rr at N_CH=16/WIDTH=1 and N_CH=5/WIDTH=8
module tb_stream_mux_rr;
   logic        clk = 1'b0;
   logic        rst16, mode16, or16, ov16, od16;
   logic [15:0] id16, iv16, ir16;
   logic [3:0]  sel16, os16;
   logic        rst5, mode5, or5, ov5;
   logic [39:0] id5;
   logic [4:0]  iv5, ir5;
   logic [2:0]  sel5, os5;
   logic [7:0]  od5;
   int          n_chk = 0;
   int          n_err = 0;
   always #5 clk = ~clk;
   stream_mux_rr #(.N_CH(16), .WIDTH(1)) u16 (
      .clk(clk), .rst_n(rst16), .In_Data(id16), .In_Valid(iv16), .In_Ready(ir16),
      .Mode(mode16), .Sel(sel16), .Out_Data(od16), .Out_Sel(os16),
      .Out_Valid(ov16), .Out_Ready(or16)
   );
   stream_mux_rr #(.N_CH(5), .WIDTH(8)) u5 (
      .clk(clk), .rst_n(rst5), .In_Data(id5), .In_Valid(iv5), .In_Ready(ir5),
      .Mode(mode5), .Sel(sel5), .Out_Data(od5), .Out_Sel(os5),
      .Out_Valid(ov5), .Out_Ready(or5)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // expect channel k to be granted now and to appear on the output next clock
   task automatic beat16(input int k);
      #1;
      check("rdy16", ir16, 64'(16'(1) << k));
      step();
      check("sel16", os16, k);
      check("dat16", od16, k % 2);
      check("vld16", ov16, 1);
   endtask
   initial begin
      rst16 = 0; mode16 = 0; or16 = 1; sel16 = 0; iv16 = 16'hFFFF; id16 = 16'hAAAA;
      rst5 = 0; mode5 = 0; or5 = 1; sel5 = 0; iv5 = 5'h1F;
      for (int k = 0; k < 5; k++) id5[k*8 +: 8] = 8'hA0 + 8'(k);
      #3;
      check("rst_vld", ov16, 0);
      check("rst_sel", os16, 0);
      check("rst_rdy", ir16, 0);
      step();
      rst16 = 1;
      beat16(0);
      for (int k = 1; k <= 16; k++) beat16(k % 16);
      beat16(1);
      iv16 = 16'h8003;
      beat16(15); beat16(0); beat16(1); beat16(15);
      iv16 = 16'h0003;
      beat16(0); beat16(1); beat16(0); beat16(1);
      iv16 = 16'h0080;
      beat16(7);
      or16 = 0; iv16 = 16'hFFFF;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("stall_rdy", ir16, 0);
         step();
         check("stall_sel", os16, 7);
         check("stall_dat", od16, 1);
         check("stall_vld", ov16, 1);
      end
      or16 = 1;
      beat16(8); beat16(9);
      mode16 = 1; iv16 = 16'h0220; sel16 = 9;
      beat16(9);
      sel16 = 5;
      beat16(5);
      sel16 = 4'(20);
      #1;
      check("fix_none_rdy", ir16, 0);
      step();
      check("fix_none_vld", ov16, 0);
      check("fix_none_sel", os16, 5);
      mode16 = 0;
      beat16(5);
      rst5 = 1;
      for (int k = 0; k < 6; k++) begin
         #1;
         check("rdy5", ir5, 64'(5'(1) << (k % 5)));
         step();
         check("dat5", od5, 8'hA0 + 8'(k % 5));
         check("sel5", os5, k % 5);
      end
      mode5 = 1; sel5 = 7;
      #1;
      check("fix5_none", ir5, 0);
      mode5 = 0;
      #1;
      rst5 = 0;
      #1;
      check("rst5_vld", ov5, 0);
      check("rst5_rdy", ir5, 0);
      check("rst5_dat", od5, 0);
      step();
      check("rst5_hold_rdy", ir5, 0);
      rst5 = 1;
      #1;
      check("rst5_first", ir5, 1);
      step();
      check("rst5_dat0", od5, 8'hA0);
      check("rst5_sel0", os5, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
